// File: rtl/pwm_pkg.sv
// PWM generator shared constants: default period, duty width, full scale,
// and the period-counter width helper.
package pwm_pkg;

  localparam int PERIOD_CYCLES = 50;
  localparam int DUTY_W        = 8;
  localparam int DUTY_MAX      = 100;

  localparam int CNT_W =
    (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Wrapping period counter 0..CYCLES-1 with a period-start strobe.
// Ports: clk, rst_n, count_next (value after this edge), start (edge begins a period).
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int CYCLES = PERIOD_CYCLES,
  parameter int WIDTH  = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] count_next,
  output logic             start
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(CYCLES - 1);

  logic [WIDTH-1:0] count;
  logic             run;

  // The first edge after reset release opens period 0, so the
  // duty present on that edge is the one that gets used.
  always_comb begin
    start      = !run || (count == LAST);
    count_next = start ? '0 : count + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      run   <= 1'b0;
    end else begin
      count <= count_next;
      run   <= 1'b1;
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// PWM generator: duty sampled at period start, saturated, scaled to high-time.
// Ports: clk, rst_n (async low), DUTY_CYCLE (percent), PWM_OUT (registered).
module pwm_generator
  import pwm_pkg::cnt_width;
#(
  parameter int PERIOD_CYCLES = pwm_pkg::PERIOD_CYCLES,
  parameter int DUTY_W        = pwm_pkg::DUTY_W,
  parameter int DUTY_MAX      = pwm_pkg::DUTY_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] DUTY_CYCLE,
  output logic              PWM_OUT
);

  localparam int CNT_W  = cnt_width(PERIOD_CYCLES);
  localparam int HIGH_W = CNT_W + 1;
  localparam int PROD_W = DUTY_W + CNT_W + 1;

  localparam logic [DUTY_W-1:0] DMAX = DUTY_W'(DUTY_MAX);

  logic [CNT_W-1:0]  count_next;
  logic              start;
  logic [DUTY_W-1:0] duty_reg;
  logic [DUTY_W-1:0] duty_sat;
  logic [DUTY_W-1:0] duty_next;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] quot;
  logic [HIGH_W-1:0] high_next;
  logic              pwm_next;

  pwm_period_counter #(
    .CYCLES (PERIOD_CYCLES),
    .WIDTH  (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_next (count_next),
    .start      (start)
  );

  // Output is computed from the post-edge counter and duty so the
  // registered waveform lines up with the period boundary: a full
  // duty never dips low at wrap and every period opens high.
  always_comb begin
    duty_sat  = (DUTY_CYCLE > DMAX) ? DMAX : DUTY_CYCLE;
    duty_next = start ? duty_sat : duty_reg;
    prod      = PROD_W'(duty_next) * PROD_W'(PERIOD_CYCLES);
    quot      = prod / PROD_W'(DUTY_MAX);
    high_next = HIGH_W'(quot);
    pwm_next  = {1'b0, count_next} < high_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_reg <= '0;
      PWM_OUT  <= 1'b0;
    end else begin
      duty_reg <= duty_next;
      PWM_OUT  <= pwm_next;
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator against a per-period waveform model.
// Ports: none.
module tb_pwm_generator;

  localparam int P = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] DUTY_CYCLE = 8'd0;
  logic       PWM_OUT;

  int n_cmp = 0;
  int n_bad = 0;
  int ones  = 0;
  bit exp_q[$];

  pwm_generator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .DUTY_CYCLE (DUTY_CYCLE),
    .PWM_OUT    (PWM_OUT)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: at each period start, the whole period's waveform is
  // queued as hi ones followed by P-hi zeros.
  task automatic step(input int d);
    int ds;
    int hi;
    bit e;
    DUTY_CYCLE = 8'(d);
    @(posedge clk);
    if (exp_q.size() == 0) begin
      ds = (d > 100) ? 100 : d;
      hi = (ds * P) / 100;
      for (int i = 0; i < P; i++) exp_q.push_back(i < hi);
    end
    e = exp_q.pop_front();
    #1;
    chk("pwm", int'(PWM_OUT), int'(e));
    if (PWM_OUT) ones++;
  endtask

  task automatic period(input int d, input int hi);
    ones = 0;
    for (int i = 0; i < P; i++) step(d);
    chk("hicnt", ones, hi);
  endtask

  initial begin
    int seq_d[9];
    int seq_h[9];
    int d;
    seq_d = '{50, 10, 90, 80, 20, 30, 40, 60, 70};
    seq_h = '{25, 5, 45, 40, 10, 15, 20, 30, 35};

    DUTY_CYCLE = 8'd50;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst", int'(PWM_OUT), 0);
    end
    rst_n = 1'b1;

    period(50, 25);
    period(50, 25);

    for (int k = 0; k < 9; k++) period(seq_d[k], seq_h[k]);

    period(0, 0);
    period(100, 50);
    period(100, 50);
    period(200, 50);
    period(255, 50);
    period(101, 50);
    period(25, 12);
    period(99, 49);
    period(1, 0);

    ones = 0;
    for (int i = 0; i < 5; i++) step(20);
    for (int i = 5; i < P; i++) step(80);
    chk("hicnt", ones, 10);
    period(80, 40);

    for (int i = 0; i < 10; i++) step(60);
    chk("prerst", int'(PWM_OUT), 1);
    #4;
    rst_n = 1'b0;
    #1;
    chk("asyncrst", int'(PWM_OUT), 0);
    @(posedge clk);
    #1;
    chk("rsthold", int'(PWM_OUT), 0);
    exp_q.delete();
    rst_n = 1'b1;
    period(60, 30);

    for (int p = 0; p < 40; p++) begin
      ones = 0;
      d = int'($urandom_range(0, 255));
      for (int i = 0; i < P; i++) begin
        if ($urandom_range(0, 9) == 0) d = int'($urandom_range(0, 255));
        step(d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter PERIOD_CYCLES, default 50, SHALL set the clock cycles per PWM period (1000 ns at 50 MHz).
REQ-003 Parameter DUTY_W, default 8, SHALL set the duty input width.
REQ-004 Parameter DUTY_MAX, default 100, SHALL set the full-scale duty value (percent).
REQ-005 Port clk SHALL be an input, 1 bit: rising-edge system clock, 50 MHz nominal.
REQ-006 Port rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-007 Port DUTY_CYCLE SHALL be an input, DUTY_W bits: requested duty in percent, unsigned.
REQ-008 Port PWM_OUT SHALL be an output, 1 bit: registered PWM waveform.

Function
REQ-009 A period counter SHALL count 0..PERIOD_CYCLES-1 and wrap to 0.
REQ-010 On the clock edge that wraps the counter to 0, DUTY_CYCLE SHALL be sampled into an internal duty register.
  - New duty takes effect only at the next period start.
  - No mid-period glitches or truncated pulses.
REQ-011 High-time in cycles SHALL be (sampled_duty * PERIOD_CYCLES) / DUTY_MAX, truncated toward zero.
  - Default parameters: this equals sampled_duty / 2.
  - Intermediate product SHALL be wide enough to avoid overflow (at least DUTY_W + 7 bits).
REQ-012 PWM_OUT SHALL be 1 while counter < high-time and 0 otherwise, registered so it changes only on rising clk edges.
REQ-013 Every period SHALL begin with PWM_OUT high, unless high-time is 0.
REQ-014 Boundary: duty 0 -> PWM_OUT constantly 0.
REQ-015 Boundary: duty equal to DUTY_MAX -> PWM_OUT constantly 1, with no low glitch at wrap.
REQ-016 Boundary: duty greater than DUTY_MAX (101..255) SHALL saturate to DUTY_MAX.
REQ-017 Boundary: odd duty values SHALL truncate (e.g. 25 -> 12 high cycles).
REQ-018 The first period after reset release SHALL use the DUTY_CYCLE value present on the first active clock edge.

Reset
REQ-019 While rst_n = 0, PWM_OUT SHALL be 0, the counter 0 and the duty register 0, all asynchronously.
REQ-020 Reset asserted mid-period SHALL force PWM_OUT low immediately.
REQ-021 After release, counting SHALL restart from 0 on the first rising clk edge.

Structure
REQ-022 Package pwm_pkg SHALL hold the default constants PERIOD_CYCLES, DUTY_MAX and DUTY_W, plus a counter-width constant derived via $clog2(PERIOD_CYCLES).
REQ-023 Sub-module pwm_period_counter SHALL implement the wrapping counter and a period-start strobe.
REQ-024 The top level SHALL contain the duty latch, saturation, high-time computation and output register.

Verification
REQ-025 Scenario: DUTY_CYCLE=50 held -> PWM_OUT high 25 cycles (500 ns) and low 25 cycles, repeating every 1000 ns.
REQ-026 Scenario: sequence 50,10,90,80,20,30,40,60,70, each held 1000 ns -> high times of 25,5,45,40,10,15,20,30,35 cycles; zero mismatches against a cycle-accurate model.
REQ-027 Scenario: duty 0 then 100 -> constant low for one full period, then constant high with no glitch at wrap.
REQ-028 Scenario: duty 200 -> identical to 100 (constant high).
REQ-029 Scenario: DUTY_CYCLE changed from 20 to 80 at cycle 5 of a period -> current period still 10 high cycles; next period 40 high cycles.
REQ-030 Scenario: rst_n pulsed low mid-high-phase with duty 60 -> PWM_OUT 0 immediately; after release, 30 high cycles then 20 low.
